fx2fp_cvt_sched: RTL and testbench
==================================

// Module: fx2fp_cvt_sched
// PURPOSE
//  Shares one sequential fixed-point -> IEEE-754 single converter between two requesters
//  (r0: ALU convert path, r1: FPU convert instruction). Round-robin arbiter, multi-cycle
//  normalize FSM, registered result with valid/ready back-pressure. Sits beside the FPU.
// PARAMETERS
//  BIAS       127  exponent bias added to packed exponent
//  NORM_STEP  1    max left-shift per NORM cycle; legal values 1, 2, 4
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  r0_valid   in   1   requester 0 has a conversion request
//  r0_data    in   32  two's-complement fixed-point operand
//  r0_frac    in   5   fraction bits; value = signed(r0_data) / 2^r0_frac
//  r0_ready   out  1   request 0 accepted this cycle when r0_valid & r0_ready
//  r1_valid / r1_data / r1_frac / r1_ready: identical, requester 1
//  res_valid  out  1   result available
//  res_id     out  1   requester owning the result
//  res_data   out  32  IEEE-754 single {sign, exp[7:0], man[22:0]}
//  res_ready  in   1   consumer takes result when res_valid & res_ready
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, res_valid=0, res_id=0, res_data=0, rr_last=1
//    (requester 0 has priority first); all internal regs cleared.
//  - States: IDLE -> NORM -> PACK -> DONE -> IDLE.
//  - IDLE: grant = only valid requester; both valid -> requester != rr_last.
//    rN_ready = (state==IDLE) & (grant==N), combinational; other ready 0. Ready is 0 in
//    all other states. On handshake: sign=data[31], mag=sign ? -data : data (32-bit
//    unsigned; 0x80000000 -> mag 0x80000000), frac, id latched; shifts=0; rr_last=id.
//  - NORM: if mag==0 or mag[31]==1 -> PACK. Else shift left by NORM_STEP when top
//    NORM_STEP bits all 0, otherwise by 1; shifts += amount. Never overshoots msb.
//  - PACK (1 cycle): mag==0 -> res_data=32'h0000_0000 (+0.0, sign dropped). Else
//    exp = BIAS + 31 - shifts - frac (9-bit internal, range 96..158, no subnormal/overflow),
//    man = mag[30:8]; res_data={sign,exp[7:0],man}; res_id=id; -> DONE.
//  - DONE: res_valid=1, res_data/res_id stable until res_valid & res_ready; that edge ->
//    IDLE, res_valid=0. New request may be accepted the cycle after (IDLE).
//  - Latency, NORM_STEP=1: res_valid rises 2+L cycles after accept edge, L=leading zeros
//    of mag (L=0 for mag==0). Max 33 cycles.
//  - Requester must hold valid/data/frac stable until ready; deassert without ready is
//    legal and simply loses arbitration that cycle (no state change).
//  - Reset mid-operation: in-flight conversion discarded, no result emitted.
// CONFIGURATION
//  FX2FP_ROUND_RNE_EN defined: PACK rounds to nearest-even: g=mag[7], s=|mag[6:0],
//    l=mag[8]; round up when g&(s|l); mantissa carry-out clears man and exp+=1.
//  Not defined: truncation (round toward zero), man=mag[30:8] only.
// TESTING
//  1 r0: data=32'h0000_0001 frac=0 -> res_data=32'h3F80_0000, res_id=0, valid 33 cycles
//    after accept (NORM_STEP=1).
//  2 r1: data=32'hFFFF_FFFF frac=0 -> 32'hBF80_0000; data=32'h0001_8000 frac=16 ->
//    32'h3FC0_0000; data=32'h8000_0000 frac=0 -> 32'hCF00_0000; data=0 -> 32'h0000_0000.
//  3 data=32'h01FF_FFFF frac=0 -> 32'h4BFF_FFFF without macro; 32'h4C00_0000 with
//    FX2FP_ROUND_RNE_EN.
//  4 r0,r1 both valid continuously for 4 requests -> grants r0,r1,r0,r1; res_id matches.
//  5 hold res_ready=0 for 10 cycles in DONE -> res_valid/res_data stable, r0/r1_ready=0;
//    res_ready=1 -> next cycle IDLE and accepts pending request.
//  6 rst_n low during NORM -> res_valid=0 immediately, state IDLE, next grant goes to r0.

Source files
------------

// File: rtl/fx2fp_cvt_sched.sv
// Shared fixed-point -> IEEE-754 single converter for two requesters.
// Round-robin arbitration in IDLE, iterative normalisation (NORM), one-cycle
// packing (PACK) and a held result with valid/ready back-pressure (DONE).
// Optional feature macro: FX2FP_ROUND_RNE_EN selects round-to-nearest-even in
// PACK; when undefined the mantissa is truncated (round toward zero).

module fx2fp_cvt_sched #(
  parameter int unsigned BIAS      = 127,
  parameter int unsigned NORM_STEP = 1    // legal values: 1, 2, 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        r0_valid,
  input  logic [31:0] r0_data,
  input  logic [4:0]  r0_frac,
  output logic        r0_ready,

  input  logic        r1_valid,
  input  logic [31:0] r1_data,
  input  logic [4:0]  r1_frac,
  output logic        r1_ready,

  output logic        res_valid,
  output logic        res_id,
  output logic [31:0] res_data,
  input  logic        res_ready
);

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StPack,
    StDone
  } state_e;

  // Bits that must all be zero before a NORM_STEP-wide shift is safe.
  localparam logic [31:0] TopMask  = ~(32'hFFFF_FFFF >> NORM_STEP);
  localparam logic [5:0]  StepAmt  = 6'(NORM_STEP);
  localparam logic [7:0]  ExpBase  = 8'(BIAS + 31);

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  frac_q, frac_d;
  logic        id_q, id_d;
  logic [5:0]  shifts_q, shifts_d;
  logic        rr_last_q, rr_last_d;
  logic        res_valid_q, res_valid_d;
  logic        res_id_q, res_id_d;
  logic [31:0] res_data_q, res_data_d;

  logic        idle;
  logic        gnt0, gnt1;
  logic        accept;
  logic [31:0] sel_data;
  logic [4:0]  sel_frac;
  logic        top_zero;
  logic [7:0]  exp_pack;
  logic [22:0] man_pack;

  // Arbitration: a lone valid requester wins; on contention the one that was not
  // served last wins. Ready is only offered to the winner while idle.
  always_comb begin
    idle     = (state_q == StIdle);
    gnt0     = r0_valid & (~r1_valid | rr_last_q);
    gnt1     = r1_valid & (~r0_valid | ~rr_last_q);
    r0_ready = idle & gnt0;
    r1_ready = idle & gnt1;
    accept   = idle & (gnt0 | gnt1);
    sel_data = gnt1 ? r1_data : r0_data;
    sel_frac = gnt1 ? r1_frac : r0_frac;
  end

  // Exponent and mantissa for the packed result. The exponent range (96..158)
  // fits in 8 bits, so modulo-256 arithmetic yields the exact field value.
  always_comb begin
    top_zero = ((mag_q & TopMask) == 32'h0);
    exp_pack = ExpBase - {2'b00, shifts_q} - {3'b000, frac_q};
    man_pack = mag_q[30:8];
`ifdef FX2FP_ROUND_RNE_EN
    begin
      logic        round_up;
      logic [23:0] man_sum;
      round_up = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
      man_sum  = {1'b0, mag_q[30:8]} + {23'h0, round_up};
      // Carry out of the mantissa leaves the field at zero and bumps the exponent.
      man_pack = man_sum[22:0];
      exp_pack = exp_pack + {7'h00, man_sum[23]};
    end
`endif
  end

  // Next-state logic for the conversion FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    frac_d      = frac_q;
    id_d        = id_q;
    shifts_d    = shifts_q;
    rr_last_d   = rr_last_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sign_d    = sel_data[31];
          // 0x8000_0000 negates to itself, which is the correct unsigned magnitude.
          mag_d     = sel_data[31] ? (~sel_data + 32'd1) : sel_data;
          frac_d    = sel_frac;
          id_d      = gnt1;
          shifts_d  = 6'd0;
          rr_last_d = gnt1;
          state_d   = StNorm;
        end
      end

      StNorm: begin
        if ((mag_q == 32'h0) || mag_q[31]) begin
          state_d = StPack;
        end else if (top_zero) begin
          mag_d    = mag_q << NORM_STEP;
          shifts_d = shifts_q + StepAmt;
        end else begin
          mag_d    = mag_q << 1;
          shifts_d = shifts_q + 6'd1;
        end
      end

      StPack: begin
        // Zero always packs as +0.0; the sign of the operand is dropped.
        if (mag_q == 32'h0) begin
          res_data_d = 32'h0000_0000;
        end else begin
          res_data_d = {sign_q, exp_pack, man_pack};
        end
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = StDone;
      end

      StDone: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sign_q      <= 1'b0;
      mag_q       <= 32'h0;
      frac_q      <= 5'h0;
      id_q        <= 1'b0;
      shifts_q    <= 6'h0;
      rr_last_q   <= 1'b1;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      frac_q      <= frac_d;
      id_q        <= id_d;
      shifts_q    <= shifts_d;
      rr_last_q   <= rr_last_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_fx2fp_cvt_sched.sv
// Self-checking bench for fx2fp_cvt_sched (default parameters, NORM_STEP=1).
// Expected results come from hand-derived vectors and an arithmetic reference
// model; FX2FP_ROUND_RNE_EN selects the rounding mode the model expects.

module tb_fx2fp_cvt_sched;

`ifdef FX2FP_ROUND_RNE_EN
  localparam bit Rne = 1'b1;
`else
  localparam bit Rne = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r1_valid;
  logic [31:0] r0_data, r1_data;
  logic [4:0]  r0_frac, r1_frac;
  logic        r0_ready, r1_ready;
  logic        res_valid, res_id, res_ready;
  logic [31:0] res_data;

  int n_checks = 0;
  int n_errors = 0;
  bit rr_last_m;

  fx2fp_cvt_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0_valid  (r0_valid),
    .r0_data   (r0_data),
    .r0_frac   (r0_frac),
    .r0_ready  (r0_ready),
    .r1_valid  (r1_valid),
    .r1_data   (r1_data),
    .r1_frac   (r1_frac),
    .r1_ready  (r1_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          id;
    logic [31:0] data;
    logic [4:0]  frac;
    logic [31:0] exp_trunc;
    logic [31:0] exp_rne;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value semantics: signed(d)/2^f, normalised by locating the leading one.
  function automatic logic [31:0] ref_cvt(input logic [31:0] d, input logic [4:0] f,
                                          output int lat);
    logic        s;
    logic [31:0] mag, norm;
    logic [22:0] man;
    logic [23:0] m;
    int          p, e;
    s   = d[31];
    mag = s ? -d : d;
    if (mag == 0) begin
      lat = 2;
      return 32'h0;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    lat  = 2 + (31 - p);
    norm = mag << (31 - p);
    e    = 127 + p - int'(f);
    man  = norm[30:8];
    if (Rne && norm[7] && ((norm[6:0] != 0) || norm[8])) begin
      m = {1'b0, man} + 24'd1;
      if (m[23]) begin
        man = 23'h0;
        e   = e + 1;
      end else begin
        man = m[22:0];
      end
    end
    return {s, e[7:0], man};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    r0_valid  = 1'b0;
    r1_valid  = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    rr_last_m = 1'b1;
  endtask

  task automatic wait_result(input string tag, output int cnt);
    cnt = 0;
    while (!res_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " valid_drop"}, 32'(res_valid), 32'd0);
  endtask

  // One request from a single requester, timed from the accept edge.
  task automatic run_one(input bit id, input logic [31:0] d, input logic [4:0] f,
                         input logic [31:0] exp_d, input int exp_lat, input string tag);
    int cnt;
    logic rdy;
    @(negedge clk);
    if (id) begin r1_valid = 1'b1; r1_data = d; r1_frac = f; end
    else    begin r0_valid = 1'b1; r0_data = d; r0_frac = f; end
    #1;
    cnt = 0;
    rdy = id ? r1_ready : r0_ready;
    while (!rdy && cnt < 50) begin
      @(negedge clk); #1;
      cnt++;
      rdy = id ? r1_ready : r0_ready;
    end
    check({tag, " accept"}, 32'(rdy), 32'd1);
    if (!rdy) begin
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      return;
    end
    @(posedge clk);
    rr_last_m = id;
    @(negedge clk);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    wait_result(tag, cnt);
    check({tag, " latency"}, 32'(cnt), 32'(exp_lat));
    check({tag, " data"}, res_data, exp_d);
    check({tag, " id"}, 32'(res_id), 32'(id));
    consume(tag);
  endtask

  initial begin
    vec_t vecs[10];
    logic [31:0] d, exp_d, held;
    logic [4:0]  f;
    bit          id, g;
    int          lat, cnt, seen;

    vecs[0] = '{1'b0, 32'h0000_0001, 5'd0,  32'h3F80_0000, 32'h3F80_0000, 33};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 5'd0,  32'hBF80_0000, 32'hBF80_0000, 33};
    vecs[2] = '{1'b1, 32'h0001_8000, 5'd16, 32'h3FC0_0000, 32'h3FC0_0000, 17};
    vecs[3] = '{1'b1, 32'h8000_0000, 5'd0,  32'hCF00_0000, 32'hCF00_0000, 2};
    vecs[4] = '{1'b1, 32'h0000_0000, 5'd0,  32'h0000_0000, 32'h0000_0000, 2};
    vecs[5] = '{1'b0, 32'h01FF_FFFF, 5'd0,  32'h4BFF_FFFF, 32'h4C00_0000, 9};
    vecs[6] = '{1'b0, 32'h7FFF_FFFF, 5'd31, 32'h3F7F_FFFF, 32'h3F80_0000, 3};
    vecs[7] = '{1'b1, 32'h0000_0003, 5'd1,  32'h3FC0_0000, 32'h3FC0_0000, 32};
    vecs[8] = '{1'b0, 32'h4000_0040, 5'd0,  32'h4E80_0000, 32'h4E80_0000, 3};
    vecs[9] = '{1'b1, 32'h4000_00C0, 5'd0,  32'h4E80_0001, 32'h4E80_0002, 3};

    rst_n = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; res_ready = 1'b0;
    r0_data = '0; r1_data = '0; r0_frac = '0; r1_frac = '0;
    apply_reset();

    // Reset state.
    #1;
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset res_data", res_data, 32'h0);
    check("reset res_id", 32'(res_id), 32'd0);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].id, vecs[i].data, vecs[i].frac,
              Rne ? vecs[i].exp_rne : vecs[i].exp_trunc, vecs[i].lat,
              $sformatf("vec%0d", i));
    end

    // Randomised single requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      d  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = -d;
      if ($urandom_range(0, 9) == 0) d = 32'h0;
      f  = 5'($urandom_range(0, 31));
      id = 1'($urandom_range(0, 1));
      exp_d = ref_cvt(d, f, lat);
      run_one(id, d, f, exp_d, lat, $sformatf("rnd%0d", i));
    end

    // Both requesters valid continuously: grants alternate starting with r0.
    apply_reset();
    r0_valid = 1'b1; r0_data = 32'h0000_0005; r0_frac = 5'd2;
    r1_valid = 1'b1; r1_data = 32'hFFFF_FFF6; r1_frac = 5'd1;
    for (int k = 0; k < 4; k++) begin
      #1;
      g = ~rr_last_m;
      check($sformatf("rr%0d r0_ready", k), 32'(r0_ready), 32'(k % 2 == 0));
      check($sformatf("rr%0d r1_ready", k), 32'(r1_ready), 32'(k % 2 == 1));
      @(posedge clk);
      rr_last_m = g;
      @(negedge clk);
      wait_result("rr", cnt);
      check($sformatf("rr%0d res_id", k), 32'(res_id), 32'(k % 2));
      check($sformatf("rr%0d data", k), res_data,
            ref_cvt(g ? r1_data : r0_data, g ? r1_frac : r0_frac, lat));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;

    // Back-pressure: result held for 10 cycles while r1 waits.
    apply_reset();
    @(negedge clk);
    r0_valid = 1'b1; r0_data = 32'h0000_0100; r0_frac = 5'd8;
    @(posedge clk);
    @(negedge clk);
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_data = 32'hFFFF_FF00; r1_frac = 5'd8;
    wait_result("bp", cnt);
    check("bp latency", 32'(cnt), 32'd25);
    held = res_data;
    check("bp data", held, 32'h3F80_0000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d valid", k), 32'(res_valid), 32'd1);
      check($sformatf("bp hold%0d data", k), res_data, 32'h3F80_0000);
      check($sformatf("bp hold%0d readys", k), {30'h0, r1_ready, r0_ready}, 32'h0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    check("bp release valid", 32'(res_valid), 32'd0);
    check("bp pending r1_ready", 32'(r1_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    r1_valid = 1'b0;
    wait_result("bp2", cnt);
    check("bp2 data", res_data, 32'hBF80_0000);
    check("bp2 id", 32'(res_id), 32'd1);
    consume("bp2");

    // Reset during NORM: nothing emitted, arbitration restarts at r0.
    @(negedge clk);
    r1_valid = 1'b1; r1_data = 32'h0000_0001; r1_frac = 5'd0;
    @(posedge clk);
    @(negedge clk);
    r1_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_norm res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    check("rst_norm r0_ready", 32'(r0_ready), 32'd1);
    check("rst_norm r1_ready", 32'(r1_ready), 32'd0);
    #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("rst_norm no result", 32'(seen), 32'd0);

    // Reset while a result is held drops it without waiting for a clock.
    rr_last_m = 1'b1;
    @(negedge clk);
    r0_valid = 1'b1; r0_data = 32'h8000_0000; r0_frac = 5'd0;
    @(posedge clk);
    @(negedge clk);
    r0_valid = 1'b0;
    wait_result("rst_done", cnt);
    check("rst_done valid_before", 32'(res_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_done res_valid", 32'(res_valid), 32'd0);
    check("rst_done res_data", res_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
